// File: rtl/scan_chain_ctrl_pkg.sv
// Shared types for the scan chain controller.
// State encoding and counter sizing helper.
package scan_chain_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE,
    CAPTURE,
    SHIFT,
    UPDATE
  } state_t;

  function automatic int clog2(input int n);
    int r;
    r = 0;
    while ((1 << r) < n) r++;
    return r;
  endfunction

endpackage

// File: rtl/scan_chain_ctrl_scan_cell.sv
// One chain bit: mux flop, d0 parallel / d1 serial.
// Loads only when sp is high; synchronous clear.
module scan_cell (
  input  logic CK,
  input  logic CD,
  input  logic d0,
  input  logic d1,
  input  logic sd,
  input  logic sp,
  output logic q
);

  always_ff @(posedge CK) begin
    if (CD) begin
      q <= 1'b0;
    end else if (sp) begin
      q <= sd ? d1 : d0;
    end
  end

endmodule

// File: rtl/scan_chain_ctrl.sv
// Capture/shift/update controller driving a chain
// of mux-flop cells in lockstep with SD/SP strobes.
module scan_chain_ctrl
  import scan_chain_ctrl_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             CK,
  input  logic             CD,
  input  logic             START,
  input  logic             CAP_EN,
  input  logic [WIDTH-1:0] PI,
  input  logic             SI,
  input  logic             SI_VALID,
  output logic             SI_READY,
  output logic             SO,
  output logic [WIDTH-1:0] PO,
  output logic             SD_O,
  output logic             SP_O,
  output logic             BUSY,
  output logic             DONE
);

  localparam int CW = clog2(WIDTH + 1);

  state_t           state;
  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] chain;
  logic [WIDTH-1:0] sin;

  assign BUSY     = (state != IDLE);
  assign SI_READY = (state == SHIFT);
  assign SD_O     = (state == SHIFT);
  assign SP_O     = (state == CAPTURE) |
                    ((state == SHIFT) & SI_VALID);
  assign SO       = chain[0];

  // serial path: SI enters at the MSB, LSB leaves first
  generate
    if (WIDTH == 1) begin : g_sin1
      assign sin = SI;
    end else begin : g_sinn
      assign sin = {SI, chain[WIDTH-1:1]};
    end
  endgenerate

  generate
    for (genvar i = 0; i < WIDTH; i++) begin : g_cell
      scan_cell u_cell (
        .CK (CK),
        .CD (CD),
        .d0 (PI[i]),
        .d1 (sin[i]),
        .sd (SD_O),
        .sp (SP_O),
        .q  (chain[i])
      );
    end
  endgenerate

  always_ff @(posedge CK) begin
    if (CD) begin
      state <= IDLE;
      cnt   <= '0;
      PO    <= '0;
      DONE  <= 1'b0;
    end else begin
      DONE <= 1'b0;
      unique case (state)
        IDLE: begin
          if (START) begin
            state <= CAP_EN ? CAPTURE : SHIFT;
            cnt   <= '0;
          end
        end
        CAPTURE: begin
          cnt   <= '0;
          state <= SHIFT;
        end
        SHIFT: begin
          if (SI_VALID) begin
            cnt <= cnt + CW'(1);
            if (cnt == CW'(WIDTH - 1)) begin
              state <= UPDATE;
            end
          end
        end
        UPDATE: begin
          PO    <= chain;
          DONE  <= 1'b1;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_scan_chain_ctrl.sv
// Directed bench for scan_chain_ctrl, WIDTH=8
// and WIDTH=1 instances on a shared clock/reset.
module tb_scan_chain_ctrl;

  logic       CK = 1'b0;
  logic       CD = 1'b1;
  logic       START = 1'b0;
  logic       CAP_EN = 1'b0;
  logic [7:0] PI = '0;
  logic       SI = 1'b0;
  logic       SI_VALID = 1'b0;
  logic       SI_READY, SO, SD_O, SP_O, BUSY, DONE;
  logic [7:0] PO;

  logic       ST1 = 1'b0;
  logic       CAP1 = 1'b0;
  logic [0:0] P1 = '0;
  logic       SI1 = 1'b0;
  logic       SV1 = 1'b0;
  logic       RDY1, SO1, SD1, SP1, BUSY1, DONE1;
  logic [0:0] PO1;

  int checks = 0;
  int failures = 0;

  always #5 CK = ~CK;

  scan_chain_ctrl #(.WIDTH(8)) dut (
    .CK(CK), .CD(CD), .START(START), .CAP_EN(CAP_EN),
    .PI(PI), .SI(SI), .SI_VALID(SI_VALID),
    .SI_READY(SI_READY), .SO(SO), .PO(PO),
    .SD_O(SD_O), .SP_O(SP_O), .BUSY(BUSY), .DONE(DONE)
  );

  scan_chain_ctrl #(.WIDTH(1)) dut1 (
    .CK(CK), .CD(CD), .START(ST1), .CAP_EN(CAP1),
    .PI(P1), .SI(SI1), .SI_VALID(SV1),
    .SI_READY(RDY1), .SO(SO1), .PO(PO1),
    .SD_O(SD1), .SP_O(SP1), .BUSY(BUSY1), .DONE(DONE1)
  );

  task automatic chk(input string tag,
                     input logic [63:0] got,
                     input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h",
               tag, got, exp);
    end
  endtask

  task automatic step;
    @(posedge CK);
    #1;
  endtask

  task automatic run(input logic [7:0] pi,
                     input logic cap,
                     input logic [7:0] si_w,
                     input int stall_at,
                     input int stall_len,
                     input logic hold,
                     output int edges,
                     output logic [7:0] so_w,
                     output int busy_n);
    int k;
    int left;
    k = 0;
    left = stall_len;
    so_w = '0;
    busy_n = 0;
    edges = -1;
    PI = pi;
    CAP_EN = cap;
    START = 1'b1;
    SI_VALID = 1'b1;
    SI = si_w[0];
    do begin
      step;
      edges++;
      if (!hold) START = 1'b0;
      if (BUSY) busy_n++;
      if (SI_READY) begin
        if (k == stall_at && left > 0) begin
          SI_VALID = 1'b0;
          left--;
          #1;
          chk("stall_sp", 64'(SP_O), 64'(0));
          chk("stall_rdy", 64'(SI_READY), 64'(1));
        end else begin
          SI_VALID = 1'b1;
          if (k < 8) begin
            so_w[k] = SO;
            SI = si_w[k];
          end
          k++;
        end
      end
    end while (!DONE && edges < 40);
    SI_VALID = 1'b0;
  endtask

  int         edges;
  int         busy_n;
  int         n;
  int         dn;
  int         sh;
  logic [7:0] so_w;

  initial begin
    CD = 1'b1;
    SI_VALID = 1'b1;
    SV1 = 1'b1;
    step;
    step;
    chk("rst_busy", 64'(BUSY), 64'(0));
    chk("rst_so", 64'(SO), 64'(0));
    chk("rst_po", 64'(PO), 64'(0));
    chk("rst_done", 64'(DONE), 64'(0));
    chk("rst_rdy", 64'(SI_READY), 64'(0));
    chk("rst_sd", 64'(SD_O), 64'(0));
    chk("rst_sp", 64'(SP_O), 64'(0));
    CD = 1'b0;
    SI_VALID = 1'b0;
    SV1 = 1'b0;
    step;

    // capture A5, shift in 1,0,1,1,0,0,1,0
    run(8'hA5, 1'b1, 8'h4D, -1, 0, 1'b0,
        edges, so_w, busy_n);
    chk("t1_edges", 64'(edges), 64'(10));
    chk("t1_so", 64'(so_w), 64'(8'hA5));
    chk("t1_po", 64'(PO), 64'(8'h4D));
    chk("t1_busy", 64'(busy_n), 64'(10));
    step;
    chk("t1_done1", 64'(DONE), 64'(0));
    chk("t1_idle", 64'(BUSY), 64'(0));

    // no capture: chain still holds 4D
    run(8'hFF, 1'b0, 8'h00, -1, 0, 1'b0,
        edges, so_w, busy_n);
    chk("t2_edges", 64'(edges), 64'(9));
    chk("t2_so", 64'(so_w), 64'(8'h4D));
    chk("t2_po", 64'(PO), 64'(8'h00));
    step;

    // three-cycle stall mid-shift
    run(8'hA5, 1'b1, 8'h4D, 4, 3, 1'b0,
        edges, so_w, busy_n);
    chk("t3_edges", 64'(edges), 64'(13));
    chk("t3_so", 64'(so_w), 64'(8'hA5));
    chk("t3_po", 64'(PO), 64'(8'h4D));
    step;

    // reset after four accepted shifts
    PI = 8'hA5;
    CAP_EN = 1'b1;
    START = 1'b1;
    SI_VALID = 1'b1;
    SI = 1'b1;
    step;
    START = 1'b0;
    for (int i = 0; i < 5; i++) step;
    chk("t4_mid_busy", 64'(BUSY), 64'(1));
    CD = 1'b1;
    step;
    CD = 1'b0;
    chk("t4_busy", 64'(BUSY), 64'(0));
    chk("t4_po", 64'(PO), 64'(0));
    chk("t4_so", 64'(SO), 64'(0));
    chk("t4_done", 64'(DONE), 64'(0));
    dn = 0;
    for (int i = 0; i < 12; i++) begin
      step;
      if (DONE) dn++;
    end
    chk("t4_nodone", 64'(dn), 64'(0));
    run(8'hA5, 1'b1, 8'h96, -1, 0, 1'b0,
        edges, so_w, busy_n);
    chk("t4_edges", 64'(edges), 64'(10));
    chk("t4_po2", 64'(PO), 64'(8'h96));
    step;

    // START held high through a transfer
    run(8'hA5, 1'b1, 8'hC3, -1, 0, 1'b1,
        edges, so_w, busy_n);
    chk("t5_edges", 64'(edges), 64'(10));
    chk("t5_po", 64'(PO), 64'(8'hC3));
    step;
    START = 1'b0;
    chk("t5_busy", 64'(BUSY), 64'(1));
    chk("t5_cap_sp", 64'(SP_O), 64'(1));
    chk("t5_cap_rdy", 64'(SI_READY), 64'(0));
    SI_VALID = 1'b1;
    SI = 1'b0;
    n = 0;
    while (!DONE && n < 40) begin
      step;
      n++;
    end
    SI_VALID = 1'b0;
    chk("t5_edges2", 64'(n), 64'(10));
    chk("t5_po2", 64'(PO), 64'(8'h00));
    step;

    // WIDTH=1 instance
    P1 = 1'b1;
    CAP1 = 1'b1;
    ST1 = 1'b1;
    SV1 = 1'b1;
    SI1 = 1'b0;
    n = -1;
    sh = 0;
    do begin
      step;
      n++;
      ST1 = 1'b0;
      if (RDY1) begin
        sh++;
        chk("w1_so", 64'(SO1), 64'(1));
      end
    end while (!DONE1 && n < 40);
    chk("w1_edges", 64'(n), 64'(3));
    chk("w1_shifts", 64'(sh), 64'(1));
    chk("w1_po", 64'(PO1), 64'(0));

    $display("TB_RESULT checks=%0d failures=%0d",
             checks, failures);
    $finish;
  end

endmodule
